// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_fsm
// Brief   : RV32I multi-cycle control unit sequencing a shared ALU and memory
// Revision: 1.0
// ============================================================================
module multicycle_control_fsm #(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_result_src,
  output logic [2:0] o_imm_src,
  output logic [3:0] o_alu_control,
  output logic       o_illegal_instr,
  output logic       o_bus_error,
  output logic [3:0] o_state
);

  // TRAP/HALT sit above 15; o_state shows their low nibble, the sticky flags disambiguate.
  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,  S_MEMWR  = 5'd5,  S_EXECR  = 5'd6,  S_EXECI  = 5'd7,
    S_ALUWB  = 5'd8,  S_BRANCH = 5'd9,  S_JAL    = 5'd10, S_JALWB  = 5'd11,
    S_JALR1  = 5'd12, S_JALR2  = 5'd13, S_LUI    = 5'd14, S_AUIPC  = 5'd15,
    S_TRAP   = 5'd16, S_HALT   = 5'd17
  } state_t;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_itype = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;

  localparam int                  c_wait_w   = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [c_wait_w-1:0] c_wait_lim = c_wait_w'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [c_wait_w-1:0] r_wait;
  logic                r_illegal;
  logic                r_bus_err;
  logic                w_ready;
  logic                w_timeout;
  logic                w_taken;

  assign w_ready   = (USE_MEM_READY == 0) ? 1'b1 : i_mem_ready;
  assign w_timeout = !w_ready && (r_wait == c_wait_lim);

  always_comb begin
    w_taken = 1'b0;
    case (i_funct3)
      3'b000:  w_taken = i_zero;
      3'b001:  w_taken = !i_zero;
      3'b100:  w_taken = i_lt;
      3'b101:  w_taken = !i_lt;
      3'b110:  w_taken = i_ltu;
      3'b111:  w_taken = !i_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter only survives while a request stalls in place, so every mem state starts at 0.
      r_wait  <= (o_mem_req && !w_ready && (w_next == r_state)) ? r_wait + c_wait_w'(1) : '0;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_next == S_HALT) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_adr_src     = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = 2'b00;
    o_alu_src_b   = 2'b00;
    o_result_src  = 2'b00;
    o_imm_src     = 3'b000;
    o_alu_control = 4'b0000;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req    = 1'b1;
          o_alu_src_b  = 2'b10;
          o_result_src = 2'b10;
          if (w_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            w_next     = S_DECODE;
          end else if (w_timeout) begin
            w_next = S_HALT;
          end
        end
        S_DECODE: begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = 2'b01;
          o_imm_src   = 3'b010;
          case (i_op)
            c_op_load, c_op_store: w_next = S_MEMADR;
            c_op_rtype:            w_next = S_EXECR;
            c_op_itype:            w_next = S_EXECI;
            c_op_br:               w_next = S_BRANCH;
            c_op_jal:              w_next = S_JAL;
            c_op_jalr:             w_next = (i_funct3 == 3'b000) ? S_JALR1 : S_TRAP;
            c_op_lui:              w_next = S_LUI;
            c_op_auipc:            w_next = S_AUIPC;
            default:               w_next = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          o_alu_src_a = 2'b10;
          o_alu_src_b = 2'b01;
          o_imm_src   = (i_op == c_op_store) ? 3'b001 : 3'b000;
          w_next      = (i_op == c_op_store) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          o_mem_req = 1'b1;
          o_adr_src = 1'b1;
          if (w_ready)        w_next = S_MEMWB;
          else if (w_timeout) w_next = S_HALT;
        end
        S_MEMWB: begin
          o_result_src = 2'b01;
          o_reg_write  = 1'b1;
          w_next       = S_FETCH;
        end
        S_MEMWR: begin
          o_mem_req = 1'b1;
          o_mem_we  = 1'b1;
          o_adr_src = 1'b1;
          if (w_ready)        w_next = S_FETCH;
          else if (w_timeout) w_next = S_HALT;
        end
        S_EXECR: begin
          o_alu_src_a   = 2'b10;
          o_alu_control = {i_funct7b5, i_funct3};
          w_next        = S_ALUWB;
        end
        S_EXECI: begin
          o_alu_src_a   = 2'b10;
          o_alu_src_b   = 2'b01;
          // Only the shift-right encoding uses bit 30 as an opcode bit; elsewhere it is immediate.
          o_alu_control = (i_funct3 == 3'b101) ? {i_funct7b5, i_funct3} : {1'b0, i_funct3};
          w_next        = S_ALUWB;
        end
        S_ALUWB: begin
          o_reg_write = 1'b1;
          w_next      = S_FETCH;
        end
        S_BRANCH: begin
          o_alu_src_a   = 2'b10;
          o_alu_control = 4'b1000;
          if (i_funct3[2:1] == 2'b01) begin
            w_next = S_TRAP;
          end else begin
            o_pc_write = w_taken;
            w_next     = S_FETCH;
          end
        end
        S_JAL: begin
          o_alu_src_a  = 2'b01;
          o_alu_src_b  = 2'b01;
          o_imm_src    = 3'b011;
          o_pc_write   = 1'b1;
          o_result_src = 2'b10;
          w_next       = S_JALWB;
        end
        S_JALWB, S_JALR1: begin
          o_alu_src_a  = 2'b01;
          o_alu_src_b  = 2'b10;
          o_reg_write  = 1'b1;
          o_result_src = 2'b10;
          w_next       = (r_state == S_JALR1) ? S_JALR2 : S_FETCH;
        end
        S_JALR2: begin
          o_alu_src_a  = 2'b10;
          o_alu_src_b  = 2'b01;
          o_pc_write   = 1'b1;
          o_result_src = 2'b10;
          w_next       = S_FETCH;
        end
        S_LUI, S_AUIPC: begin
          o_alu_src_a = (r_state == S_LUI) ? 2'b11 : 2'b01;
          o_alu_src_b = 2'b01;
          o_imm_src   = 3'b100;
          w_next      = S_ALUWB;
        end
        S_TRAP, S_HALT: w_next = r_state;
        default:        w_next = S_FETCH;
      endcase
    end
  end

  assign o_illegal_instr = r_illegal && !rst;
  assign o_bus_error     = r_bus_err && !rst;
  assign o_state         = rst ? 4'h0 : r_state[3:0];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control_fsm
// Brief   : directed scenarios plus random instruction stream vs. a step model
// Revision: 1.0
// ============================================================================
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, lt, ltu, ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] src_a, src_b, res_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctl, state_dbg;
  logic       illegal, bus_err;
  int         n_run  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.USE_MEM_READY(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7),
    .i_zero(zero), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(ready),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_adr_src(adr_src),
    .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
    .o_alu_src_a(src_a), .o_alu_src_b(src_b), .o_result_src(res_src),
    .o_imm_src(imm_src), .o_alu_control(alu_ctl), .o_illegal_instr(illegal),
    .o_bus_error(bus_err), .o_state(state_dbg)
  );

  wire [20:0] w_act = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                       src_a, src_b, res_src, imm_src, alu_ctl, illegal, bus_err};

  // {req,we,adr,ir,pc,rw,a,b,res,imm,alu,ill,bus}
  function automatic logic [20:0] ev(input int req, we, adr, ir, pc, rw, a, b, res, imm, alu, ill, bus);
    return {req[0], we[0], adr[0], ir[0], pc[0], rw[0], a[1:0], b[1:0], res[1:0],
            imm[2:0], alu[3:0], ill[0], bus[0]};
  endfunction

  logic [20:0] e_fwait, e_fdone, e_dec, e_trap, e_halt;
  localparam logic [20:0] STROBES = 21'h038000;

  typedef struct { logic mem; logic [20:0] v; } step_t;
  step_t plan[$];
  logic  plan_trap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic add_step(input logic mem, input logic [20:0] v);
    step_t s;
    s.mem = mem; s.v = v;
    plan.push_back(s);
  endtask

  // Expected cycle-by-cycle control for one instruction, from its class and operands.
  task automatic build(input logic [6:0] o, input logic [2:0] fn, input logic b30,
                       input logic [31:0] ra, input logic [31:0] rb);
    logic taken;
    plan.delete();
    plan_trap = 1'b0;
    add_step(1'b1, e_fdone);
    add_step(1'b0, e_dec);
    case (o)
      7'b0000011: begin
        add_step(1'b0, ev(0,0,0,0,0,0, 2,1,0,0,0, 0,0));
        add_step(1'b1, ev(1,0,1,0,0,0, 0,0,0,0,0, 0,0));
        add_step(1'b0, ev(0,0,0,0,0,1, 0,0,1,0,0, 0,0));
      end
      7'b0100011: begin
        add_step(1'b0, ev(0,0,0,0,0,0, 2,1,0,1,0, 0,0));
        add_step(1'b1, ev(1,1,1,0,0,0, 0,0,0,0,0, 0,0));
      end
      7'b0110011: begin
        add_step(1'b0, ev(0,0,0,0,0,0, 2,0,0,0,int'({b30, fn}), 0,0));
        add_step(1'b0, ev(0,0,0,0,0,1, 0,0,0,0,0, 0,0));
      end
      7'b0010011: begin
        add_step(1'b0, ev(0,0,0,0,0,0, 2,1,0,0,(fn == 3'd5) ? int'({b30, fn}) : int'(fn), 0,0));
        add_step(1'b0, ev(0,0,0,0,0,1, 0,0,0,0,0, 0,0));
      end
      7'b1100011: begin
        case (fn)
          3'd0:    taken = (ra == rb);
          3'd1:    taken = (ra != rb);
          3'd4:    taken = ($signed(ra) <  $signed(rb));
          3'd5:    taken = ($signed(ra) >= $signed(rb));
          3'd6:    taken = (ra <  rb);
          3'd7:    taken = (ra >= rb);
          default: taken = 1'b0;
        endcase
        add_step(1'b0, ev(0,0,0,0,int'(taken),0, 2,0,0,0,8, 0,0));
        plan_trap = (fn == 3'd2) || (fn == 3'd3);
      end
      7'b1101111: begin
        add_step(1'b0, ev(0,0,0,0,1,0, 1,1,2,3,0, 0,0));
        add_step(1'b0, ev(0,0,0,0,0,1, 1,2,2,0,0, 0,0));
      end
      7'b1100111: begin
        if (fn != 3'd0) plan_trap = 1'b1;
        else begin
          add_step(1'b0, ev(0,0,0,0,0,1, 1,2,2,0,0, 0,0));
          add_step(1'b0, ev(0,0,0,0,1,0, 2,1,2,0,0, 0,0));
        end
      end
      7'b0110111, 7'b0010111: begin
        add_step(1'b0, ev(0,0,0,0,0,0, (o == 7'b0110111) ? 3 : 1,1,0,4,0, 0,0));
        add_step(1'b0, ev(0,0,0,0,0,1, 0,0,0,0,0, 0,0));
      end
      default: plan_trap = 1'b1;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b0; op = 7'd0; f3 = 3'd0; f7 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0;
    @(negedge clk);
    n_run++;
    if (w_act !== 21'd0 || state_dbg !== 4'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%h want 0/0", w_act, state_dbg);
    end
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if (w_act !== e_fwait) begin
      n_fail++; $display("FAIL fetch_after_reset: got %h want %h", w_act, e_fwait);
    end
    tick();
  endtask

  task automatic test_add();
    logic [31:0] ins;
    logic [20:0] ex [5];
    ins = 32'h002081B3;
    do_reset();
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[30]; ready = 1'b1;
    ex = '{e_fdone, e_dec, ev(0,0,0,0,0,0, 2,0,0,0,0, 0,0), ev(0,0,0,0,0,1, 0,0,0,0,0, 0,0), e_fdone};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_run++;
      if (w_act !== ex[i]) begin
        n_fail++; $display("FAIL add cyc%0d: got %h want %h", i, w_act, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    logic [7:0]  rdy;
    logic [20:0] ex [8];
    logic [20:0] rd;
    rd  = ev(1,0,1,0,0,0, 0,0,0,0,0, 0,0);
    rdy = 8'b1100_0111;
    ex  = '{e_fdone, e_dec, ev(0,0,0,0,0,0, 2,1,0,0,0, 0,0), rd, rd, rd, rd,
            ev(0,0,0,0,0,1, 0,0,1,0,0, 0,0)};
    do_reset();
    op = 7'b0000011; f3 = 3'b010; f7 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ready = rdy[i];
      @(negedge clk);
      n_run++;
      if (w_act !== ex[i]) begin
        n_fail++; $display("FAIL lw_wait cyc%0d: got %h want %h", i, w_act, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [20:0] e;
    for (int j = 0; j < 2; j++) begin
      do_reset();
      op = 7'b1100011; f3 = (j == 0) ? 3'b001 : 3'b000; zero = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ready = (i == 0);
        e = (i == 0) ? e_fdone : (i == 1) ? e_dec :
            (i == 2) ? ev(0,0,0,0,(j == 0) ? 1 : 0,0, 2,0,0,0,8, 0,0) : e_fwait;
        @(negedge clk);
        n_run++;
        if (w_act !== e) begin
          n_fail++; $display("FAIL branch%0d cyc%0d: got %h want %h", j, i, w_act, e);
        end
        tick();
      end
    end
  endtask

  task automatic test_timeout();
    logic [20:0] e;
    do_reset();
    op = 7'b0110011; f3 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      ready = 1'b0;
      e = (i < 4) ? e_fwait : e_halt;
      @(negedge clk);
      n_run++;
      if (w_act !== e) begin
        n_fail++; $display("FAIL timeout cyc%0d: got %h want %h", i, w_act, e);
      end
      tick();
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ready = (i == 3);
      e = (i < 3) ? e_fwait : (i == 3) ? e_fdone : e_dec;
      @(negedge clk);
      n_run++;
      if (w_act !== e) begin
        n_fail++; $display("FAIL ready_at_limit cyc%0d: got %h want %h", i, w_act, e);
      end
      tick();
    end
  endtask

  task automatic test_trap();
    logic [20:0] e;
    do_reset();
    op = 7'b1111111;
    for (int i = 0; i < 7; i++) begin
      ready = (i == 0) || (i == 6);
      rst   = (i == 5);
      e = (i == 0) ? e_fdone : (i == 1) ? e_dec : (i < 5) ? e_trap : (i == 5) ? 21'd0 : e_fdone;
      @(negedge clk);
      n_run++;
      if (w_act !== e) begin
        n_fail++; $display("FAIL trap cyc%0d: got %h want %h", i, w_act, e);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic test_jalr();
    logic [20:0] ex [5];
    ex = '{e_fdone, e_dec, ev(0,0,0,0,0,1, 1,2,2,0,0, 0,0), ev(0,0,0,0,1,0, 2,1,2,0,0, 0,0), e_fwait};
    do_reset();
    op = 7'b1100111; f3 = 3'b000;
    for (int i = 0; i < 5; i++) begin
      ready = (i == 0);
      @(negedge clk);
      n_run++;
      if (w_act !== ex[i]) begin
        n_fail++; $display("FAIL jalr cyc%0d: got %h want %h", i, w_act, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_abort();
    logic [20:0] ex [6];
    ex = '{e_fdone, e_dec, ev(0,0,0,0,0,0, 2,1,0,1,0, 0,0), ev(1,1,1,0,0,0, 0,0,0,0,0, 0,0),
           21'd0, e_fwait};
    do_reset();
    op = 7'b0100011; f3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      ready = (i == 0);
      rst   = (i == 4);
      @(negedge clk);
      n_run++;
      if (w_act !== ex[i]) begin
        n_fail++; $display("FAIL abort cyc%0d: got %h want %h", i, w_act, ex[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] ra, rb;
    logic [20:0] e;
    int          idx, waits;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    do_reset();
    for (int k = 0; k < 80; k++) begin
      idx = $urandom_range(0, 9);
      op  = (idx == 9) ? 7'($urandom) : ops[idx];
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      zero = (ra == rb);
      lt   = ($signed(ra) < $signed(rb));
      ltu  = (ra < rb);
      build(op, f3, f7, ra, rb);
      for (int s = 0; s < plan.size(); s++) begin
        waits = plan[s].mem ? $urandom_range(0, 3) : 0;
        for (int w = 0; w <= waits; w++) begin
          ready = plan[s].mem ? (w == waits) : 1'($urandom);
          e = (w == waits) ? plan[s].v : (plan[s].v & ~STROBES);
          @(negedge clk);
          n_run++;
          if (w_act !== e) begin
            n_fail++; $display("FAIL rand op=%b f3=%0d step%0d: got %h want %h", op, f3, s, w_act, e);
          end
          tick();
        end
      end
      if (plan_trap) begin
        ready = 1'($urandom);
        @(negedge clk);
        n_run++;
        if (w_act !== e_trap) begin
          n_fail++; $display("FAIL rand_trap op=%b f3=%0d: got %h want %h", op, f3, w_act, e_trap);
        end
        do_reset();
      end
    end
  endtask

  initial begin
    e_fwait = ev(1,0,0,0,0,0, 0,2,2,0,0, 0,0);
    e_fdone = ev(1,0,0,1,1,0, 0,2,2,0,0, 0,0);
    e_dec   = ev(0,0,0,0,0,0, 1,1,0,2,0, 0,0);
    e_trap  = ev(0,0,0,0,0,0, 0,0,0,0,0, 1,0);
    e_halt  = ev(0,0,0,0,0,0, 0,0,0,0,0, 0,1);
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_timeout();
    test_trap();
    test_jalr();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
